// File: rtl/bu_pipe_pkg.sv
// Shared types for the BU pipeline-control chain: per-stage token and hazard-mode encodings.
package bu_pipe_pkg;

    localparam int HAZARD_INTERLOCK = 0;
    localparam int HAZARD_FWD       = 1;

    // Token fields are sized for the widest supported core; instances use the low bits.
    localparam int DATA_W_MAX = 64;
    localparam int REG_AW_MAX = 8;

    typedef struct packed {
        logic                  valid;
        logic                  wen;
        logic                  ld;
        logic [REG_AW_MAX-1:0] dst;
        logic [DATA_W_MAX-1:0] data;
    } stage_t;

    function automatic int reg_aw(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

endpackage

// File: rtl/bu_hazard_check.sv
// RAW hazard detector: compares issuing sources against in-flight writers.
module bu_hazard_check
    import bu_pipe_pkg::*;
#(
    parameter int STAGES      = 5,
    parameter int REG_AW      = 3,
    parameter int HAZARD_MODE = HAZARD_INTERLOCK
) (
    input  stage_t [STAGES-1:0] st,
    input  logic [REG_AW-1:0]   src_a,
    input  logic [REG_AW-1:0]   src_b,
    input  logic                use_a,
    input  logic                use_b,
    output logic                hazard
);

    logic [REG_AW_MAX-1:0] src_a_x;
    logic [REG_AW_MAX-1:0] src_b_x;
    logic                  hit;

    assign src_a_x = REG_AW_MAX'(src_a);
    assign src_b_x = REG_AW_MAX'(src_b);

    // Retire stage is excluded: the register file forwards write-first.
    always_comb begin
        hazard = 1'b0;
        hit    = 1'b0;
        for (int j = 0; j < STAGES-1; j++) begin
            hit = st[j].valid & st[j].wen &
                  ((use_a & (st[j].dst == src_a_x)) | (use_b & (st[j].dst == src_b_x)));
            if (HAZARD_MODE == HAZARD_INTERLOCK)
                hazard = hazard | hit;
            else if (j == 0)
                hazard = hazard | (hit & st[j].ld);
        end
    end

endmodule

// File: rtl/bu_pipe_ctrl.sv
// Pipeline-control chain: token shift register with hold, redirect flush, RAW stall and perf counters.
module bu_pipe_ctrl
    import bu_pipe_pkg::*;
#(
    parameter int STAGES      = 5,
    parameter int DATA_W      = 16,
    parameter int NREGS       = 8,
    parameter int FLUSH_DEPTH = 3,
    parameter int HAZARD_MODE = HAZARD_INTERLOCK,
    localparam int REG_AW     = reg_aw(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [REG_AW-1:0] in_dst,
    input  logic              in_wen,
    input  logic              in_ld,
    input  logic [REG_AW-1:0] in_src_a,
    input  logic [REG_AW-1:0] in_src_b,
    input  logic              in_use_a,
    input  logic              in_use_b,
    input  logic              hold,
    input  logic              redirect,
    output logic              redirect_ack,
    output logic [STAGES-1:0] stage_valid,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_AW-1:0] out_dst,
    output logic              out_wen,
    output logic [15:0]       perf_retired,
    output logic [15:0]       perf_bubbles
);

    stage_t [STAGES-1:0] st_q, st_d;
    logic [15:0]         retired_q, retired_d;
    logic [15:0]         bubbles_q, bubbles_d;
    logic                hazard;
    logic                issue;

    bu_hazard_check #(
        .STAGES      (STAGES),
        .REG_AW      (REG_AW),
        .HAZARD_MODE (HAZARD_MODE)
    ) u_hazard (
        .st     (st_q),
        .src_a  (in_src_a),
        .src_b  (in_src_b),
        .use_a  (in_use_a),
        .use_b  (in_use_b),
        .hazard (hazard)
    );

    assign in_ready     = ~hold & ~hazard & ~redirect;
    assign redirect_ack = redirect & ~hold;
    assign issue        = in_valid & in_ready;

    always_comb begin
        st_d      = st_q;
        retired_d = retired_q;
        bubbles_d = bubbles_q;
        if (!hold) begin
            // Tokens leaving stages 0..FLUSH_DEPTH-1 are squashed on their way forward.
            for (int k = 1; k < STAGES; k++) begin
                st_d[k] = st_q[k-1];
                if (redirect && (k <= FLUSH_DEPTH))
                    st_d[k].valid = 1'b0;
            end
            st_d[0] = '0;
            if (issue) begin
                st_d[0].valid = 1'b1;
                st_d[0].wen   = in_wen;
                st_d[0].ld    = in_ld;
                st_d[0].dst   = REG_AW_MAX'(in_dst);
                st_d[0].data  = DATA_W_MAX'(in_data);
            end
            if (st_q[STAGES-1].valid)
                retired_d = retired_q + 16'd1;
            if (in_valid && hazard && !redirect)
                bubbles_d = bubbles_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q      <= '0;
            retired_q <= '0;
            bubbles_q <= '0;
        end else begin
            st_q      <= st_d;
            retired_q <= retired_d;
            bubbles_q <= bubbles_d;
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++)
            stage_valid[k] = st_q[k].valid;
    end

    assign out_valid    = st_q[STAGES-1].valid;
    assign out_data     = st_q[STAGES-1].data[DATA_W-1:0];
    assign out_dst      = st_q[STAGES-1].dst[REG_AW-1:0];
    assign out_wen      = st_q[STAGES-1].valid & st_q[STAGES-1].wen;
    assign perf_retired = retired_q;
    assign perf_bubbles = bubbles_q;

endmodule

// File: tb/tb_bu_pipe_ctrl.sv
// Directed bench: interlock instance (u_dut0) and forwarding instance (u_dut1) on shared inputs.
module tb_bu_pipe_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid0, in_valid1;
    logic [15:0] in_data;
    logic [2:0]  in_dst, in_src_a, in_src_b;
    logic        in_wen, in_ld, in_use_a, in_use_b;
    logic        hold, redirect;

    logic        in_ready0, in_ready1, ack0, ack1;
    logic [4:0]  sv0, sv1;
    logic        ov0, ov1, ow0, ow1;
    logic [15:0] od0, od1;
    logic [2:0]  odst0, odst1;
    logic [15:0] ret0, ret1, bub0, bub1;

    int checks = 0;
    int errors = 0;

    bu_pipe_ctrl #(.HAZARD_MODE(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
        .in_data(in_data), .in_dst(in_dst), .in_wen(in_wen), .in_ld(in_ld),
        .in_src_a(in_src_a), .in_src_b(in_src_b), .in_use_a(in_use_a), .in_use_b(in_use_b),
        .hold(hold), .redirect(redirect), .redirect_ack(ack0), .stage_valid(sv0),
        .out_valid(ov0), .out_data(od0), .out_dst(odst0), .out_wen(ow0),
        .perf_retired(ret0), .perf_bubbles(bub0)
    );

    bu_pipe_ctrl #(.HAZARD_MODE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_data(in_data), .in_dst(in_dst), .in_wen(in_wen), .in_ld(in_ld),
        .in_src_a(in_src_a), .in_src_b(in_src_b), .in_use_a(in_use_a), .in_use_b(in_use_b),
        .hold(hold), .redirect(redirect), .redirect_ack(ack1), .stage_valid(sv1),
        .out_valid(ov1), .out_data(od1), .out_dst(odst1), .out_wen(ow1),
        .perf_retired(ret1), .perf_bubbles(bub1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid0 = 0; in_valid1 = 0; in_data = '0; in_dst = '0;
        in_wen = 0; in_ld = 0; in_src_a = '0; in_src_b = '0; in_use_a = 0; in_use_b = 0;
        hold = 0; redirect = 0;
        #3;
        chk("rst_sv", 32'(sv0), 32'h0);
        chk("rst_ov", 32'(ov0), 32'h0);
        chk("rst_ow", 32'(ow0), 32'h0);
        chk("rst_ret", 32'(ret0), 32'h0);
        chk("rst_bub", 32'(bub0), 32'h0);
        #9 rst_n = 1'b1;
        tick();
        chk("idle_ready", 32'(in_ready0), 32'h1);

        // Latency: one token through both instances
        in_valid0 = 1; in_valid1 = 1; in_data = 16'h1234; in_dst = 3'd3; in_wen = 1;
        tick();
        in_valid0 = 0; in_valid1 = 0;
        chk("lat_sv_e", 32'(sv0), 32'h01);
        repeat (3) tick();
        chk("lat_not_yet", 32'(ov0), 32'h0);
        tick();
        chk("lat_ov", 32'(ov0), 32'h1);
        chk("lat_data", 32'(od0), 32'h1234);
        chk("lat_dst", 32'(odst0), 32'h3);
        chk("lat_wen", 32'(ow0), 32'h1);
        chk("lat_ret_pre", 32'(ret0), 32'h0);
        tick();
        chk("lat_ret", 32'(ret0), 32'h1);
        chk("lat_ret1", 32'(ret1), 32'h1);
        chk("lat_drained", 32'(ov0), 32'h0);

        // Interlock: writer dst=2, dependent reads src_a=2
        in_valid0 = 1; in_dst = 3'd2; in_wen = 1; in_ld = 0;
        tick();
        in_dst = 3'd5; in_data = 16'hBEEF; in_use_a = 1; in_src_a = 3'd2;
        for (int i = 0; i < 4; i++) begin
            #1 chk("il_stall", 32'(in_ready0), 32'h0);
            tick();
        end
        chk("il_release", 32'(in_ready0), 32'h1);
        chk("il_bubbles", 32'(bub0), 32'd4);
        tick();
        in_valid0 = 0;
        chk("il_dep_sv", 32'(sv0), 32'h01);
        chk("il_ret", 32'(ret0), 32'd2);
        repeat (5) tick();
        chk("il_drain_ret", 32'(ret0), 32'd3);

        // Forwarding: ALU producer never stalls, load producer costs one bubble
        in_use_a = 0; in_valid1 = 1; in_dst = 3'd2; in_wen = 1; in_ld = 0;
        tick();
        in_dst = 3'd4; in_use_a = 1; in_src_a = 3'd2;
        #1 chk("fw_alu_ready", 32'(in_ready1), 32'h1);
        tick();
        chk("fw_alu_sv", 32'(sv1), 32'h03);
        chk("fw_alu_bub", 32'(bub1), 32'h0);
        in_use_a = 0; in_dst = 3'd6; in_ld = 1;
        tick();
        in_ld = 0; in_dst = 3'd7; in_use_b = 1; in_src_b = 3'd6;
        #1 chk("fw_ld_stall", 32'(in_ready1), 32'h0);
        tick();
        chk("fw_ld_release", 32'(in_ready1), 32'h1);
        chk("fw_ld_bub", 32'(bub1), 32'd1);
        tick();
        in_valid1 = 0;
        chk("fw_ld_sv", 32'(sv1), 32'h1D);
        in_use_b = 0;
        repeat (5) tick();

        // Redirect: stages 0..3 full, flush
        in_wen = 0; in_valid0 = 1;
        for (int i = 0; i < 4; i++) begin
            in_data = 16'hA000 + 16'(i);
            tick();
        end
        chk("rd_fill_sv", 32'(sv0), 32'h0F);
        redirect = 1;
        #1 chk("rd_ack", 32'(ack0), 32'h1);
        chk("rd_ready", 32'(in_ready0), 32'h0);
        tick();
        redirect = 0; in_valid0 = 0;
        chk("rd_sv", 32'(sv0), 32'h10);
        chk("rd_out", 32'(od0), 32'hA000);
        chk("rd_bub", 32'(bub0), 32'd4);
        tick();
        chk("rd_ret", 32'(ret0), 32'd4);

        // Hold with pending redirect on a full chain
        in_valid0 = 1;
        for (int i = 0; i < 5; i++) begin
            in_data = 16'hB000 + 16'(i);
            tick();
        end
        chk("hd_fill_sv", 32'(sv0), 32'h1F);
        hold = 1; redirect = 1;
        #1 chk("hd_ack", 32'(ack0), 32'h0);
        chk("hd_ready", 32'(in_ready0), 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hd_sv", 32'(sv0), 32'h1F);
            chk("hd_ret", 32'(ret0), 32'd4);
            chk("hd_out", 32'(od0), 32'hB000);
            chk("hd_ack_held", 32'(ack0), 32'h0);
        end
        hold = 0;
        #1 chk("hd_ack_rel", 32'(ack0), 32'h1);
        tick();
        redirect = 0;
        chk("hd_flush_sv", 32'(sv0), 32'h10);
        chk("hd_flush_out", 32'(od0), 32'hB001);
        chk("hd_flush_ret", 32'(ret0), 32'd5);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) tick();
        in_valid0 = 0;
        chk("mr_sv", 32'(sv0), 32'h07);
        rst_n = 0;
        #1;
        chk("mr_sv0", 32'(sv0), 32'h0);
        chk("mr_ret0", 32'(ret0), 32'h0);
        chk("mr_bub0", 32'(bub0), 32'h0);
        chk("mr_bub1", 32'(bub1), 32'h0);
        #1 rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mr_no_out", 32'(ov0), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
